// File: rtl/async_axis_fifo_pkg.sv
// Shared types and helpers for the dual-clock AXIS FIFO controllers.
// Gray conversions are width-agnostic up to 32 bits; callers zero-extend in and truncate out.
package async_axis_fifo_pkg;

   localparam int OUT_BUF_DEPTH = 2;

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/async_axis_fifo_sync.sv
// N-stage vector synchroniser for Gray-coded pointers crossing clock domains.
// Shared by the read and write controllers of the dual-clock AXIS FIFO.
module async_axis_fifo_sync #(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] sync_q [STAGES];

   // Plain flop chain: nothing may sit between stages or metastability settling time is lost.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/async_axis_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock AXIS FIFO: empty detection, BRAM reads, 2-entry skid output.
// Optional macro ASYNC_AXIS_FIFO_RD_LEVEL_EN adds the registered m_axis_level port.
module async_axis_fifo_rd_ctrl
   import async_axis_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 5,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [ADDRESS_WIDTH:0]   wr_ptr_gray,
   output logic [ADDRESS_WIDTH:0]   rd_ptr_gray,
   output logic                     ram_reb,
   output logic [ADDRESS_WIDTH-1:0] ram_addrb,
   input  logic [DATA_WIDTH-1:0]    ram_doutb,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [DATA_WIDTH-1:0]    m_axis_tdata
`ifdef ASYNC_AXIS_FIFO_RD_LEVEL_EN
   ,
   output logic [ADDRESS_WIDTH:0]   m_axis_level
`endif
);

   localparam int PTR_W = ADDRESS_WIDTH + 1;
   localparam int CNT_W = $clog2(OUT_BUF_DEPTH + 1);

   logic [PTR_W-1:0]      wr_ptr_sync;
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      rd_ptr_inc;
   logic [PTR_W-1:0]      rd_ptr_gray_q;
   logic                  inflight;
   logic [CNT_W-1:0]      buf_count;
   logic [CNT_W-1:0]      buf_count_after_pop;
   logic [CNT_W-1:0]      buf_count_next;
   logic [CNT_W:0]        occ;
   logic [DATA_WIDTH-1:0] buf_head;
   logic [DATA_WIDTH-1:0] buf_tail;
   logic [DATA_WIDTH-1:0] head_next;
   logic [DATA_WIDTH-1:0] tail_next;
   logic                  tvalid_q;
   logic                  empty;
   logic                  pop;
   logic                  issue;

   async_axis_fifo_sync #(
      .WIDTH  (PTR_W),
      .STAGES (SYNC_STAGES)
   ) u_wr_ptr_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (wr_ptr_gray),
      .q      (wr_ptr_sync)
   );

   // The registered Gray pointer always equals the Gray form of the next address to read,
   // so empty compares it directly against the synchronised write pointer.
   always_comb begin
      empty      = (rd_ptr_gray_q == wr_ptr_sync);
      pop        = tvalid_q && m_axis_tready;
      occ        = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight};
      issue      = !empty && ((occ - {{CNT_W{1'b0}}, pop}) < (CNT_W+1)'(OUT_BUF_DEPTH));
      rd_ptr_inc = rd_ptr + PTR_W'(1);
   end

   assign ram_reb     = issue;
   assign ram_addrb   = rd_ptr[ADDRESS_WIDTH-1:0];
   assign rd_ptr_gray = rd_ptr_gray_q;

   // The slot is handed back to the writer on issue; the BRAM samples the address on this
   // same edge, long before the writer can see the new pointer through its synchroniser.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr        <= '0;
         rd_ptr_gray_q <= '0;
         inflight      <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            rd_ptr        <= rd_ptr_inc;
            rd_ptr_gray_q <= PTR_W'(bin2gray(32'(rd_ptr_inc)));
         end
      end
   end

   // Returning BRAM data lands in the head when the buffer will be empty after this
   // cycle's pop, otherwise behind whatever is still waiting.
   always_comb begin
      head_next           = buf_head;
      tail_next           = buf_tail;
      buf_count_after_pop = buf_count - CNT_W'(pop);
      if (pop && (buf_count == CNT_W'(2))) begin
         head_next = buf_tail;
      end
      if (inflight) begin
         if (buf_count_after_pop == '0) begin
            head_next = ram_doutb;
         end else begin
            tail_next = ram_doutb;
         end
      end
      buf_count_next = buf_count_after_pop + CNT_W'(inflight);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_count <= '0;
         buf_head  <= '0;
         buf_tail  <= '0;
         tvalid_q  <= 1'b0;
      end else begin
         buf_count <= buf_count_next;
         buf_head  <= head_next;
         buf_tail  <= tail_next;
         tvalid_q  <= (buf_count_next != '0);
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = buf_head;

`ifdef ASYNC_AXIS_FIFO_RD_LEVEL_EN
   logic [PTR_W-1:0] wr_ptr_sync_bin;
   logic [PTR_W-1:0] level_q;

   assign wr_ptr_sync_bin = PTR_W'(gray2bin(32'(wr_ptr_sync)));

   // Words visible to the reader: not yet issued plus those already sitting in the buffer.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         level_q <= '0;
      end else begin
         level_q <= wr_ptr_sync_bin - rd_ptr + PTR_W'(buf_count);
      end
   end

   assign m_axis_level = level_q;
`endif

endmodule

// File: tb/tb_async_axis_fifo_rd_ctrl.sv
// Self-checking bench for async_axis_fifo_rd_ctrl: vector table plus directed multi-cycle sequences.
module tb_async_axis_fifo_rd_ctrl;

   localparam int DW    = 16;
   localparam int AW    = 5;
   localparam int PW    = AW + 1;
   localparam int DEPTH = 32;
   localparam int NV    = 11;

   typedef struct {
      logic [PW-1:0] wr_bin;
      logic          tready;
      logic          exp_reb;
      logic [AW-1:0] exp_addr;
      logic          exp_tvalid;
      logic [DW-1:0] exp_tdata;
      logic          chk_tdata;
      logic [PW-1:0] exp_rd_gray;
   } vec_t;

   logic          clk = 1'b0;
   logic          resetn;
   logic [PW-1:0] wr_ptr_gray;
   logic [PW-1:0] rd_ptr_gray;
   logic          ram_reb;
   logic [AW-1:0] ram_addrb;
   logic [DW-1:0] ram_doutb = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [DW-1:0] m_axis_tdata;
`ifdef ASYNC_AXIS_FIFO_RD_LEVEL_EN
   logic [PW-1:0] m_axis_level;
`endif

   logic [DW-1:0] mem [DEPTH];
   vec_t          vecs [NV];
   int            checks = 0;
   int            errors = 0;

   async_axis_fifo_rd_ctrl #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .SYNC_STAGES   (2)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .wr_ptr_gray   (wr_ptr_gray),
      .rd_ptr_gray   (rd_ptr_gray),
      .ram_reb       (ram_reb),
      .ram_addrb     (ram_addrb),
      .ram_doutb     (ram_doutb),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata)
`ifdef ASYNC_AXIS_FIFO_RD_LEVEL_EN
      ,
      .m_axis_level  (m_axis_level)
`endif
   );

   always #5 clk = ~clk;

   // Dual-port BRAM read port with one clock of read latency.
   always @(posedge clk) begin
      if (ram_reb) ram_doutb <= mem[ram_addrb];
   end

   function automatic logic [PW-1:0] tb_bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PW-1:0] tb_gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives inputs just after the falling edge and leaves time for outputs to settle.
   task automatic applyStimulus(input logic [PW-1:0] wr_bin, input logic tready);
      @(negedge clk);
      wr_ptr_gray   = tb_bin2gray(wr_bin);
      m_axis_tready = tready;
      #1;
   endtask

   task automatic doReset();
      @(negedge clk);
      resetn        = 1'b0;
      wr_ptr_gray   = '0;
      m_axis_tready = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int beats, issues, got, wr, exp_word, issued;
      bit started;
      logic [PW-1:0] rd_bin, fill;

      resetn        = 1'b0;
      wr_ptr_gray   = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      mem[0] = 16'hA5A5;

      // wr, rdy, reb, addr, tvalid, tdata, chk, rd_gray
      vecs[0]  = '{6'd0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[1]  = '{6'd0, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[2]  = '{6'd0, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[3]  = '{6'd0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[4]  = '{6'd1, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[5]  = '{6'd1, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[6]  = '{6'd1, 1'b1, 1'b1, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd0};
      vecs[7]  = '{6'd1, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b1, 6'd1};
      vecs[8]  = '{6'd1, 1'b1, 1'b0, 5'd0, 1'b1, 16'hA5A5, 1'b1, 6'd1};
      vecs[9]  = '{6'd1, 1'b1, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 6'd1};
      vecs[10] = '{6'd1, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 6'd1};

      doReset();
`ifdef ASYNC_AXIS_FIFO_RD_LEVEL_EN
      checkOutput("reset_level", m_axis_level, 0);
`endif

      $display("[TB] vector table: idle after reset, then a single word");
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].wr_bin, vecs[i].tready);
         checkOutput($sformatf("vec%0d_reb", i), ram_reb, vecs[i].exp_reb);
         if (vecs[i].exp_reb) checkOutput($sformatf("vec%0d_addr", i), ram_addrb, vecs[i].exp_addr);
         checkOutput($sformatf("vec%0d_tvalid", i), m_axis_tvalid, vecs[i].exp_tvalid);
         if (vecs[i].chk_tdata) checkOutput($sformatf("vec%0d_tdata", i), m_axis_tdata, vecs[i].exp_tdata);
         checkOutput($sformatf("vec%0d_rd_gray", i), rd_ptr_gray, vecs[i].exp_rd_gray);
      end

      $display("[TB] full-depth burst with tready held high");
      doReset();
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
      beats   = 0;
      started = 0;
      for (int cyc = 0; cyc < 80 && beats < DEPTH; cyc++) begin
         applyStimulus(6'd32, 1'b1);
         if (m_axis_tvalid) begin
            started = 1;
            checkOutput("burst_data", m_axis_tdata, beats);
            beats++;
         end else if (started) begin
            checkOutput("burst_no_bubble", m_axis_tvalid, 1);
         end
      end
      checkOutput("burst_beats", beats, DEPTH);
      applyStimulus(6'd32, 1'b1);
      checkOutput("burst_rd_gray", rd_ptr_gray, 6'b110000);
      checkOutput("burst_idle_tvalid", m_axis_tvalid, 0);
      checkOutput("burst_idle_reb", ram_reb, 0);

      $display("[TB] back-pressure with five words available");
      doReset();
      for (int i = 0; i < 5; i++) mem[i] = 16'h0100 + DW'(i);
      issues = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         applyStimulus(6'd5, 1'b0);
         if (ram_reb) issues++;
         if (cyc >= 6) begin
            checkOutput("stall_tvalid", m_axis_tvalid, 1);
            checkOutput("stall_tdata", m_axis_tdata, 16'h0100);
         end
      end
      checkOutput("stall_issues", issues, 2);
      got = 0;
      for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
         applyStimulus(6'd5, 1'b1);
         if (ram_reb) issues++;
         if (m_axis_tvalid) begin
            checkOutput("release_data", m_axis_tdata, 16'h0100 + got);
            got++;
         end
      end
      checkOutput("release_words", got, 5);
      applyStimulus(6'd5, 1'b1);
      checkOutput("release_done_tvalid", m_axis_tvalid, 0);
      checkOutput("release_total_issues", issues, 5);

      $display("[TB] random tready over three pointer wraps");
      doReset();
      wr       = 0;
      exp_word = 0;
      issued   = 0;
      for (int cyc = 0; cyc < 3000 && exp_word < 96; cyc++) begin
         @(negedge clk);
         m_axis_tready = 1'($urandom_range(0, 1));
         rd_bin        = tb_gray2bin(rd_ptr_gray);
         fill          = PW'(wr) - rd_bin;
         if (wr < 96 && fill < PW'(DEPTH) && $urandom_range(0, 3) != 0) begin
            mem[wr % DEPTH] = DW'(wr);
            wr++;
         end
         wr_ptr_gray = tb_bin2gray(PW'(wr));
         #1;
         if (ram_reb) begin
            checkOutput("rand_reb_nonempty", (issued < wr), 1);
            checkOutput("rand_reb_addr", ram_addrb, issued % DEPTH);
            issued++;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            checkOutput("rand_data", m_axis_tdata, exp_word);
            exp_word++;
         end
      end
      checkOutput("rand_words", exp_word, 96);

      $display("[TB] asynchronous reset with words buffered");
      doReset();
      for (int i = 0; i < 5; i++) mem[i] = 16'h0200 + DW'(i);
      for (int cyc = 0; cyc < 8; cyc++) applyStimulus(6'd5, 1'b0);
      checkOutput("pre_reset_tvalid", m_axis_tvalid, 1);
      @(negedge clk);
      #2;
      resetn      = 1'b0;
      wr_ptr_gray = '0;
      #1;
      checkOutput("async_reset_tvalid", m_axis_tvalid, 0);
      checkOutput("async_reset_rd_gray", rd_ptr_gray, 0);
      checkOutput("async_reset_reb", ram_reb, 0);
      checkOutput("async_reset_tdata", m_axis_tdata, 0);
`ifdef ASYNC_AXIS_FIFO_RD_LEVEL_EN
      checkOutput("async_reset_level", m_axis_level, 0);
`endif
      @(negedge clk);
      resetn = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         applyStimulus(6'd0, 1'b1);
         checkOutput("post_reset_tvalid", m_axis_tvalid, 0);
         checkOutput("post_reset_reb", ram_reb, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
